alu_exec_unit: RTL and testbench

Integer execute stage fed directly by the ALU reservation station. Accepts at most one ready ALU operation per cycle (control code, ROB tag, two resolved 32-bit operands) and computes the result in a single cycle. Buffers results in a small in-order result FIFO until the common-data-bus arbiter grants the slot. Back-pressures the reservation station with `stall` (the station's `e_hc.stall`) when the buffer is full, and is cleared by branch-mispredict flush.

---
 rtl/mips_core_pkg.sv | 31 +++
 rtl/alu_result_fifo.sv | 63 ++++++
 rtl/alu_exec_unit.sv | 83 ++++++++
 tb/tb_alu_exec_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared core definitions: ALU control encoding and execute-stage result record.
package mips_core_pkg;

  localparam int unsigned ALU_CTL_WIDTH       = 4;
  localparam int unsigned ALU_EXEC_FIFO_DEPTH = 2;
  localparam int unsigned ALU_DATA_WIDTH      = 32;
  localparam int unsigned ALU_TAG_WIDTH       = 4;

  typedef enum logic [ALU_CTL_WIDTH-1:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDU = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_SLL  = 4'd10,
    ALU_SRL  = 4'd11,
    ALU_SRA  = 4'd12,
    ALU_LUI  = 4'd13
  } alu_ctl_t;

  typedef struct packed {
    logic [ALU_TAG_WIDTH-1:0]  tag;
    logic [ALU_DATA_WIDTH-1:0] data;
  } alu_result_t;

endpackage

// File: rtl/alu_result_fifo.sv
// In-order result buffer between the ALU and the CDB arbiter; synchronous clear, async reset.
module alu_result_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 36
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign rdata     = mem[rd_ptr];
  assign occupancy = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Single-cycle integer execute stage with an in-order result buffer toward the CDB.
module alu_exec_unit
  import mips_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned FIFO_DEPTH = ALU_EXEC_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          issue_valid,
  input  logic [ALU_CTL_WIDTH-1:0]      issue_alu_ctl,
  input  logic [TAG_WIDTH-1:0]          issue_tag,
  input  logic [DATA_WIDTH-1:0]         issue_op1,
  input  logic [DATA_WIDTH-1:0]         issue_op2,
  output logic                          stall,
  output logic                          cdb_req,
  output logic [TAG_WIDTH-1:0]          cdb_tag,
  output logic [DATA_WIDTH-1:0]         cdb_data,
  input  logic                          cdb_grant,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  localparam int unsigned SH_W = $clog2(DATA_WIDTH);

  alu_ctl_t                         ctl;
  logic [DATA_WIDTH-1:0]            result;
  logic [SH_W-1:0]                  shamt;
  logic                             accept;
  logic                             pop;
  logic                             full;
  logic                             empty;
  logic [TAG_WIDTH+DATA_WIDTH-1:0]  head;

  assign ctl   = alu_ctl_t'(issue_alu_ctl);
  assign shamt = issue_op2[SH_W-1:0];

  always_comb begin
    result = '0;
    case (ctl)
      ALU_ADD, ALU_ADDU: result = issue_op1 + issue_op2;
      ALU_SUB, ALU_SUBU: result = issue_op1 - issue_op2;
      ALU_AND:           result = issue_op1 & issue_op2;
      ALU_OR:            result = issue_op1 | issue_op2;
      ALU_XOR:           result = issue_op1 ^ issue_op2;
      ALU_NOR:           result = ~(issue_op1 | issue_op2);
      ALU_SLT:           result = DATA_WIDTH'($signed(issue_op1) < $signed(issue_op2));
      ALU_SLTU:          result = DATA_WIDTH'(issue_op1 < issue_op2);
      ALU_SLL:           result = issue_op1 << shamt;
      ALU_SRL:           result = issue_op1 >> shamt;
      ALU_SRA:           result = DATA_WIDTH'($signed(issue_op1) >>> shamt);
      ALU_LUI:           result = issue_op2 << 16;
      default:           result = '0;
    endcase
  end

  // stall comes only from the registered count, so a full buffer refuses issue even while popping
  assign stall   = full;
  assign accept  = issue_valid && !stall && !flush;
  assign cdb_req = !empty;
  assign pop     = cdb_req && cdb_grant;

  alu_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TAG_WIDTH + DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (accept),
    .pop       (pop),
    .wdata     ({issue_tag, result}),
    .rdata     (head),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  assign cdb_tag  = head[TAG_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign cdb_data = head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: arithmetic, buffering, stall, wrap, flush and async reset.
module tb_alu_exec_unit;
  import mips_core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        issue_valid;
  logic [3:0]  issue_alu_ctl;
  logic [3:0]  issue_tag;
  logic [31:0] issue_op1;
  logic [31:0] issue_op2;
  logic        stall;
  logic        cdb_req;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_grant;
  logic [1:0]  occupancy;

  int total;
  int bad;

  alu_exec_unit #(
    .DATA_WIDTH (32),
    .TAG_WIDTH  (4),
    .FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_alu_ctl (issue_alu_ctl),
    .issue_tag     (issue_tag),
    .issue_op1     (issue_op1),
    .issue_op2     (issue_op2),
    .stall         (stall),
    .cdb_req       (cdb_req),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data),
    .cdb_grant     (cdb_grant),
    .occupancy     (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input alu_ctl_t c, input logic [3:0] t,
                       input logic [31:0] a, input logic [31:0] b);
    issue_valid   = v;
    issue_alu_ctl = c;
    issue_tag     = t;
    issue_op1     = a;
    issue_op2     = b;
  endtask

  task automatic head_is(input string nm, input logic [3:0] t, input logic [31:0] d);
    chk({nm, "_req"},  64'(cdb_req),  64'(1));
    chk({nm, "_tag"},  64'(cdb_tag),  64'(t));
    chk({nm, "_data"}, 64'(cdb_data), 64'(d));
  endtask

  logic [3:0]  q_tag[$];
  logic [31:0] q_dat[$];
  logic [31:0] pop_seen[$];

  initial begin
    logic acc, pp;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    cdb_grant = 1'b0;
    issue(1'b0, ALU_ADD, 4'd0, 32'd0, 32'd0);

    // reset state
    #12;
    chk("rst_req",  64'(cdb_req),   64'(0));
    chk("rst_stall",64'(stall),     64'(0));
    chk("rst_occ",  64'(occupancy), 64'(0));
    chk("rst_tag",  64'(cdb_tag),   64'(0));
    chk("rst_data", 64'(cdb_data),  64'(0));
    #1 rst_n = 1'b1;

    // single ADD with grant held
    cdb_grant = 1'b1;
    issue(1'b1, ALU_ADD, 4'd3, 32'd5, 32'd7);
    tick();
    head_is("add", 4'd3, 32'd12);
    issue(1'b0, ALU_ADD, 4'd0, 32'd0, 32'd0);
    tick();
    chk("add_drained", 64'(cdb_req), 64'(0));

    // back-to-back ops, one result per cycle
    issue(1'b1, ALU_SUB, 4'd1, 32'd0, 32'd1);
    tick();
    head_is("sub", 4'd1, 32'hFFFF_FFFF);
    issue(1'b1, ALU_SLT, 4'd2, 32'hFFFF_FFFF, 32'd1);
    tick();
    head_is("slt", 4'd2, 32'd1);
    chk("b2b_occ", 64'(occupancy), 64'(1));
    issue(1'b1, ALU_SLTU, 4'd3, 32'hFFFF_FFFF, 32'd1);
    tick();
    head_is("sltu", 4'd3, 32'd0);
    issue(1'b1, ALU_SRA, 4'd4, 32'h8000_0000, 32'd4);
    tick();
    head_is("sra", 4'd4, 32'hF800_0000);
    issue(1'b1, ALU_LUI, 4'd5, 32'd0, 32'h0000_1234);
    tick();
    head_is("lui", 4'd5, 32'h1234_0000);
    issue(1'b1, ALU_NOR, 4'd6, 32'h0F0F_0000, 32'h0000_00F0);
    tick();
    head_is("nor", 4'd6, 32'hF0F0_FF0F);
    issue(1'b1, alu_ctl_t'(4'd15), 4'd7, 32'd9, 32'd9);
    tick();
    head_is("undef", 4'd7, 32'd0);
    issue(1'b0, ALU_ADD, 4'd0, 32'd0, 32'd0);
    tick();
    chk("b2b_drained", 64'(cdb_req), 64'(0));

    // fill without grants, stall, release
    cdb_grant = 1'b0;
    issue(1'b1, ALU_ADD, 4'd1, 32'd100, 32'd1);
    tick();
    chk("f1_occ",   64'(occupancy), 64'(1));
    chk("f1_stall", 64'(stall),     64'(0));
    issue(1'b1, ALU_ADD, 4'd2, 32'd200, 32'd2);
    tick();
    chk("f2_occ",   64'(occupancy), 64'(2));
    chk("f2_stall", 64'(stall),     64'(1));
    issue(1'b1, ALU_ADD, 4'd3, 32'd300, 32'd3);
    tick();
    chk("f3_stall", 64'(stall),     64'(1));
    chk("f3_occ",   64'(occupancy), 64'(2));
    head_is("f3_head", 4'd1, 32'd101);
    cdb_grant = 1'b1;
    tick();
    chk("f4_stall", 64'(stall),     64'(0));
    chk("f4_occ",   64'(occupancy), 64'(1));
    head_is("f4_head", 4'd2, 32'd202);
    cdb_grant = 1'b0;
    tick();
    chk("f5_occ", 64'(occupancy), 64'(2));
    head_is("f5_head", 4'd2, 32'd202);
    issue(1'b0, ALU_ADD, 4'd0, 32'd0, 32'd0);
    cdb_grant = 1'b1;
    tick();
    head_is("f6_head", 4'd3, 32'd303);
    chk("f6_occ", 64'(occupancy), 64'(1));
    tick();
    chk("f7_req", 64'(cdb_req), 64'(0));

    // continuous issue with alternating grants; a queue tracks expected contents
    for (int i = 0; i < 20; i++) begin
      issue(1'b1, ALU_ADD, 4'(i), 32'(i), 32'd1000);
      cdb_grant = i[0];
      acc = (q_tag.size() < 2);
      pp  = cdb_grant && (q_tag.size() > 0);
      tick();
      if (pp) begin
        pop_seen.push_back(q_dat[0]);
        void'(q_tag.pop_front());
        void'(q_dat.pop_front());
      end
      if (acc) begin
        q_tag.push_back(4'(i));
        q_dat.push_back(32'(i) + 32'd1000);
      end
      chk("wrap_occ",   64'(occupancy), 64'(q_tag.size()));
      chk("wrap_stall", 64'(stall),     64'(q_tag.size() == 2));
      if (q_tag.size() > 0) head_is("wrap_head", q_tag[0], q_dat[0]);
      else chk("wrap_req", 64'(cdb_req), 64'(0));
    end
    for (int k = 1; k < pop_seen.size(); k++)
      chk("wrap_order", 64'(pop_seen[k] > pop_seen[k-1]), 64'(1));

    // flush with two entries held and an issue in the flush cycle
    issue(1'b0, ALU_ADD, 4'd0, 32'd0, 32'd0);
    cdb_grant = 1'b1;
    tick();
    tick();
    chk("pre_flush_req", 64'(cdb_req), 64'(0));
    cdb_grant = 1'b0;
    issue(1'b1, ALU_OR, 4'd5, 32'h50, 32'h05);
    tick();
    issue(1'b1, ALU_OR, 4'd6, 32'h60, 32'h06);
    tick();
    chk("pre_flush_occ", 64'(occupancy), 64'(2));
    flush = 1'b1;
    issue(1'b1, ALU_OR, 4'd7, 32'h70, 32'h07);
    tick();
    chk("flush_req",   64'(cdb_req),   64'(0));
    chk("flush_occ",   64'(occupancy), 64'(0));
    chk("flush_stall", 64'(stall),     64'(0));
    flush = 1'b0;
    issue(1'b0, ALU_ADD, 4'd0, 32'd0, 32'd0);
    tick();
    chk("flush_dropped", 64'(cdb_req), 64'(0));
    issue(1'b1, ALU_XOR, 4'd8, 32'hFF, 32'h0F);
    tick();
    head_is("post_flush", 4'd8, 32'hF0);

    // asynchronous reset mid-cycle with a full buffer
    issue(1'b1, ALU_ADD, 4'd9, 32'd1, 32'd1);
    tick();
    chk("prerst_occ", 64'(occupancy), 64'(2));
    issue(1'b0, ALU_ADD, 4'd0, 32'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",   64'(cdb_req),   64'(0));
    chk("arst_stall", 64'(stall),     64'(0));
    chk("arst_occ",   64'(occupancy), 64'(0));
    chk("arst_data",  64'(cdb_data),  64'(0));
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_req", 64'(cdb_req), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
